// File: rtl/instr_mem_loadable.sv
// ============================================================================
// Module   : instr_mem_loadable
// Purpose  : Instruction memory loaded at runtime over valid/ready, then read
//            by the fetch stage with a registered one-cycle response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_mem_loadable #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}},
    parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [CNT_W-1:0]  load_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    output logic [1:0]        state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMP_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q,       state_d;
    logic [CNT_W-1:0]  count_q,       count_d;
    logic              done_q,        done_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_data_q,  fetch_data_d;
    logic              fetch_err_q,   fetch_err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              beat_acc;
    logic              addr_in_range;

    // The write pointer always equals the number of words loaded so far.
    assign beat_acc      = (state_q == LOAD) && load_valid;
    assign addr_in_range = ({{(CMP_W-ADDR_W){1'b0}}, fetch_addr} <
                            {{(CMP_W-CNT_W){1'b0}}, count_q});

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        done_d        = done_q;
        fetch_valid_d = fetch_req;
        fetch_data_d  = fetch_data_q;
        fetch_err_d   = fetch_err_q;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (beat_acc) begin
                    count_d = count_q + CNT_W'(1);
                    if (load_last || (count_q == CNT_W'(DEPTH - 1))) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Fetch is answered from the pre-edge state and length.
        if (fetch_req) begin
            if ((state_q == RUN) && addr_in_range) begin
                fetch_data_d = mem[fetch_addr[IDX_W-1:0]];
                fetch_err_d  = 1'b0;
            end else begin
                fetch_data_d = NOP_WORD;
                fetch_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            done_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= NOP_WORD;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            done_q        <= done_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Storage is deliberately not reset; load_count gates its visibility.
    always_ff @(posedge clk) begin
        if (rst_n && beat_acc) begin
            mem[count_q[IDX_W-1:0]] <= load_data;
        end
    end

    assign load_ready  = (state_q == LOAD);
    assign load_done   = done_q;
    assign load_count  = count_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_err   = fetch_err_q;
    assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
// ============================================================================
// Module   : tb_instr_mem_loadable
// Purpose  : Directed self-checking bench for instr_mem_loadable (DEPTH 256
//            and DEPTH 4 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_mem_loadable;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        load_start, load_valid, load_last;
    logic [15:0] load_data;
    logic        load_ready, load_done;
    logic [8:0]  load_count;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_valid, fetch_err;
    logic [15:0] fetch_data;
    logic [1:0]  state;

    logic        load_start4, load_valid4, load_last4;
    logic [15:0] load_data4;
    logic        load_ready4, load_done4;
    logic [2:0]  load_count4;
    logic        fetch_req4;
    logic [7:0]  fetch_addr4;
    logic        fetch_valid4, fetch_err4;
    logic [15:0] fetch_data4;
    logic [1:0]  state4;

    int checks = 0;
    int errors = 0;

    logic [15:0] prog [5] = '{16'h4A6A, 16'h9902, 16'h3405, 16'h11A0, 16'h221F};
    logic [15:0] prog4 [4] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};

    always #5 clk = ~clk;

    instr_mem_loadable dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_count(load_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
        .state(state)
    );

    instr_mem_loadable #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start4), .load_valid(load_valid4), .load_data(load_data4),
        .load_last(load_last4), .load_ready(load_ready4), .load_done(load_done4),
        .load_count(load_count4), .fetch_req(fetch_req4), .fetch_addr(fetch_addr4),
        .fetch_valid(fetch_valid4), .fetch_data(fetch_data4), .fetch_err(fetch_err4),
        .state(state4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (state !== 2'd0 || load_ready !== 1'b0 || load_done !== 1'b0 || load_count !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d ready=%b done=%b count=%0d, want 0/0/0/0",
                     state, load_ready, load_done, load_count);
        end
        checks++;
        if (fetch_valid !== 1'b0 || fetch_data !== 16'h0000 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch: valid=%b data=%h err=%b, want 0/0000/0",
                     fetch_valid, fetch_data, fetch_err);
        end
        rst_n = 1'b1;
        fetch_req = 1'b1; fetch_addr = 8'd0;
        step();
        fetch_req = 1'b0;
        checks++;
        if (fetch_valid !== 1'b1 || fetch_data !== 16'h0000 || fetch_err !== 1'b1 || state !== 2'd0) begin
            errors++;
            $display("FAIL idle_fetch: valid=%b data=%h err=%b state=%0d, want 1/0000/1/0",
                     fetch_valid, fetch_data, fetch_err, state);
        end
    endtask

    task automatic test_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        checks++;
        if (state !== 2'd1 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_enter: state=%0d ready=%b, want 1/1", state, load_ready);
        end
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == 4);
            // Final beat collides with a fetch: answered as a LOAD-state fetch
            fetch_req  = (i == 4);
            fetch_addr = 8'd0;
            step();
            load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
            if (i == 4) begin
                checks++;
                if (fetch_valid !== 1'b1 || fetch_data !== 16'h0000 || fetch_err !== 1'b1) begin
                    errors++;
                    $display("FAIL last_beat_fetch: valid=%b data=%h err=%b, want 1/0000/1",
                             fetch_valid, fetch_data, fetch_err);
                end
            end
            step();
        end
        checks++;
        if (load_count !== 9'd5 || load_done !== 1'b1 || state !== 2'd2 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_end: count=%0d done=%b state=%0d ready=%b, want 5/1/2/0",
                     load_count, load_done, state, load_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 8'(i);
            step();
            checks++;
            if (fetch_valid !== 1'b1 || fetch_data !== prog[i] || fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_fetch[%0d]: valid=%b data=%h err=%b, want 1/%h/0",
                         i, fetch_valid, fetch_data, fetch_err, prog[i]);
            end
        end
        fetch_req = 1'b0;
        step();
        checks++;
        if (fetch_valid !== 1'b0 || fetch_data !== 16'h221F || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold: valid=%b data=%h err=%b, want 0/221f/0",
                     fetch_valid, fetch_data, fetch_err);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] addrs [2] = '{8'd5, 8'd255};
        for (int i = 0; i < 2; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = addrs[i];
            step();
            fetch_req = 1'b0;
            checks++;
            if (fetch_valid !== 1'b1 || fetch_data !== 16'h0000 || fetch_err !== 1'b1) begin
                errors++;
                $display("FAIL oor_fetch[%0d]: valid=%b data=%h err=%b, want 1/0000/1",
                         addrs[i], fetch_valid, fetch_data, fetch_err);
            end
        end
    endtask

    task automatic test_depth4();
        load_start4 = 1'b1;
        step();
        load_start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid4 = 1'b1;
            load_data4  = prog4[i];
            load_last4  = 1'b0;
            step();
        end
        checks++;
        if (state4 !== 2'd2 || load_count4 !== 3'd4 || load_ready4 !== 1'b0 || load_done4 !== 1'b1) begin
            errors++;
            $display("FAIL d4_full: state=%0d count=%0d ready=%b done=%b, want 2/4/0/1",
                     state4, load_count4, load_ready4, load_done4);
        end
        load_data4 = 16'hFFFF;
        step();
        load_valid4 = 1'b0;
        fetch_req4 = 1'b1; fetch_addr4 = 8'd0;
        step();
        checks++;
        if (load_count4 !== 3'd4 || fetch_data4 !== 16'hA001 || fetch_err4 !== 1'b0) begin
            errors++;
            $display("FAIL d4_extra_beat: count=%0d data=%h err=%b, want 4/a001/0",
                     load_count4, fetch_data4, fetch_err4);
        end
        fetch_addr4 = 8'd3;
        step();
        checks++;
        if (fetch_data4 !== 16'hD004 || fetch_err4 !== 1'b0) begin
            errors++;
            $display("FAIL d4_last_word: data=%h err=%b, want d004/0", fetch_data4, fetch_err4);
        end
        fetch_addr4 = 8'd4;
        step();
        fetch_req4 = 1'b0;
        checks++;
        if (fetch_valid4 !== 1'b1 || fetch_data4 !== 16'h0000 || fetch_err4 !== 1'b1) begin
            errors++;
            $display("FAIL d4_oor: valid=%b data=%h err=%b, want 1/0000/1",
                     fetch_valid4, fetch_data4, fetch_err4);
        end
    endtask

    task automatic test_restart();
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 8'd1;
        step();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        checks++;
        if (fetch_valid !== 1'b1 || fetch_data !== 16'h9902 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL restart_fetch: valid=%b data=%h err=%b, want 1/9902/0",
                     fetch_valid, fetch_data, fetch_err);
        end
        checks++;
        if (state !== 2'd1 || load_done !== 1'b0 || load_count !== 9'd0) begin
            errors++;
            $display("FAIL restart_state: state=%0d done=%b count=%0d, want 1/0/0",
                     state, load_done, load_count);
        end
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        checks++;
        if (fetch_data !== 16'h0000 || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL load_state_fetch: data=%h err=%b, want 0000/1", fetch_data, fetch_err);
        end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            step();
        end
        load_valid = 1'b0;
        checks++;
        if (load_count !== 9'd2 || state !== 2'd1) begin
            errors++;
            $display("FAIL partial_load: count=%0d state=%0d, want 2/1", load_count, state);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (state !== 2'd0 || load_count !== 9'd0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset: state=%0d count=%0d done=%b, want 0/0/0",
                     state, load_count, load_done);
        end
        fetch_req = 1'b1; fetch_addr = 8'd0;
        step();
        fetch_req = 1'b0;
        checks++;
        if (fetch_valid !== 1'b1 || fetch_data !== 16'h0000 || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_fetch: valid=%b data=%h err=%b, want 1/0000/1",
                     fetch_valid, fetch_data, fetch_err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        fetch_req = 1'b0; fetch_addr = '0;
        load_start4 = 1'b0; load_valid4 = 1'b0; load_last4 = 1'b0; load_data4 = '0;
        fetch_req4 = 1'b0; fetch_addr4 = '0;

        test_reset();
        test_load();
        test_back_to_back();
        test_out_of_range();
        test_depth4();
        test_restart();
        test_reset_midload();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
